// File: rtl/cache_port_responder.sv
// Direct-mapped write-through no-write-allocate cache answering one pipeline memory port.
// Latency: read hit 0 cycles; read miss / write LATENCY busy cycles (2*LATENCY with both_access extension).
// Backpressure: ready drops for the whole fill/write; hit stays low until the transaction is answered.
//
// Ports:
//   clk, reset                      - rising-edge clock, synchronous active-high reset
//   req, we, addr, wdata            - pipeline access (addr is a word address: tag | index | offset)
//   rdata, hit, ready               - answer to the pipeline / hazard controller
//   both_access                     - hazard controller is servicing I and D misses together
//   mem_read, mem_write             - line fill / word write-through strobes to the shared memory model
//   mem_addr, mem_wdata, mem_rdata  - latched transaction address/data, returned 64-bit line
//   access_cnt, miss_cnt            - saturating statistics
module cache_port_responder #(
    parameter int LATENCY     = 4,
    parameter int LINES       = 4,
    parameter int SECOND_PORT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        hit,
    output logic        ready,
    input  logic        both_access,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic [15:0] access_cnt,
    output logic [15:0] miss_cnt
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 14 - IDX_W;
    // Wide enough for 2*LATENCY-1 (countdown after a both_access extension).
    localparam int CNT_W = $clog2(2 * LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAT_M1 = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ext, ext_nxt;
    logic             wr_done;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [63:0]      data_mem [LINES];

    // Field decode of the live request and of the latched transaction.
    logic [IDX_W-1:0] idx, lat_idx;
    logic [TAG_W-1:0] tag, lat_tag;
    logic [1:0]       off, lat_off;

    assign idx     = addr[2+IDX_W-1:2];
    assign tag     = addr[15:2+IDX_W];
    assign off     = addr[1:0];
    assign lat_idx = mem_addr[2+IDX_W-1:2];
    assign lat_tag = mem_addr[15:2+IDX_W];
    assign lat_off = mem_addr[1:0];

    logic idle, tag_match, read_hit, write_hit, miss, extend, done;

    assign idle      = (state == IDLE);
    assign tag_match = valid[idx] && (tag_mem[idx] == tag);
    assign read_hit  = idle && req && !we && tag_match;
    // A write is acknowledged only in the cycle right after its write-through finished.
    assign write_hit = idle && req && we && wr_done && (addr == mem_addr);
    assign miss      = idle && req && (we ? !wr_done : !tag_match);
    // One extension per transaction; it wins over completion on the same edge.
    assign extend    = (SECOND_PORT != 0) && !idle && both_access && !ext;
    assign done      = !idle && (cnt == '0) && !extend;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ext_nxt   = ext;
        ready     = 1'b0;
        hit       = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        rdata     = 16'h0000;
        case (state)
            IDLE: begin
                ready = 1'b1;
                hit   = !req || read_hit || write_hit;
                if (read_hit) begin
                    rdata = data_mem[idx][{off, 4'b0000} +: 16];
                end
                if (miss) begin
                    state_nxt = we ? WRITE : FILL;
                    cnt_nxt   = CNT_LAT_M1;
                end
            end
            FILL, WRITE: begin
                mem_read  = (state == FILL);
                mem_write = (state == WRITE);
                if (extend) begin
                    // +LATENCY for the extension, -1 for this cycle's countdown.
                    ext_nxt = 1'b1;
                    cnt_nxt = cnt + CNT_LAT_M1;
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                    ext_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ext        <= 1'b0;
            wr_done    <= 1'b0;
            valid      <= '0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
            access_cnt <= 16'h0000;
            miss_cnt   <= 16'h0000;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ext     <= ext_nxt;
            wr_done <= (state == WRITE) && done;
            if (miss) begin
                mem_addr  <= we ? addr : {addr[15:2], 2'b00};
                mem_wdata <= wdata;
            end
            if ((state == FILL) && done) begin
                valid[lat_idx] <= 1'b1;
            end
            if ((read_hit || write_hit || miss) && (access_cnt != 16'hFFFF)) begin
                access_cnt <= access_cnt + 16'd1;
            end
            if (miss && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

    // Tag/data arrays carry no reset: contents are meaningless while valid is clear.
    always_ff @(posedge clk) begin
        if ((state == FILL) && done) begin
            tag_mem[lat_idx]  <= lat_tag;
            data_mem[lat_idx] <= mem_rdata;
        end else if ((state == WRITE) && done && valid[lat_idx] && (tag_mem[lat_idx] == lat_tag)) begin
            data_mem[lat_idx][{lat_off, 4'b0000} +: 16] <= mem_wdata;
        end
    end

endmodule
